dmem_pattern_seq: RTL and testbench
===================================

# dmem_pattern_seq

- Parametrised successor to the fixed Q15 data-memory constant table.
- Holds a PERIOD-entry pattern that repeats across a 2^AW logical address space.
- Provides a registered random-access read port and a ready/valid streaming sequencer that replays the pattern from any base address for a programmed length.
- Sits between the FPU test/data path and its operand feeders; an optional load port makes the pattern runtime-writable.

## Interface
- DW, 16: data width in bits, DW ≥ 8.
- AW, 9: logical address width.
- PERIOD, 20: number of physical pattern entries, 2 ≤ PERIOD ≤ 2^AW.
- clk in 1: the single clock; all state updates on its rising edge.
- rst in 1: synchronous, active-high reset.
- rd_en in 1: random read request.
- rd_addr in AW: logical read address.
- rd_data out DW: read result.
- rd_valid out 1: rd_data valid.
- st_start in 1: start a stream (sampled only in IDLE).
- st_base in AW: stream start address.
- st_len in AW: stream length in words; 0 means no stream is started.
- s_valid out 1: stream word valid.
- s_ready in 1: downstream accept.
- s_data out DW: stream word.
- s_last out 1: final word of the stream.
- st_busy out 1: sequencer not IDLE.
- wr_en in 1: pattern load strobe (DMEM_LOAD_EN only).
- wr_idx in clog2(PERIOD): physical entry to write (DMEM_LOAD_EN only).
- wr_data in DW: load data (DMEM_LOAD_EN only).

## Operation
- **Default pattern:** entries 0..19 hold the 16-bit Q15 values 7FFF, 0C88, 1897, 1446, 0000, 1446, F99E, 0C88, FCCA, 0000, 0336, F378, 0662, EBBA, 0000, EBBA, E769, F378, 8000, 0000.
- **Entries past the table:** entry k for k ≥ 20 holds the default value of k mod 20.
- **Width scaling:**
  - DW > 16: value left-aligned, {v, (DW-16)'b0}.
  - DW < 16: v[15 -: DW].
- **Address mapping:** physical index = logical address mod PERIOD, a constant-divisor modulo.
- **Random port:** rd_en in cycle N produces rd_data = entry[rd_addr mod PERIOD] and rd_valid = 1 in cycle N+1. rd_data holds its value when rd_en = 0.
- **Sequencer FSM**, states IDLE and RUN:
  - IDLE: on st_start with st_len ≠ 0, load idx = st_base mod PERIOD and rem = st_len, then go to RUN.
  - IDLE: st_start with st_len = 0 is ignored.
  - RUN: s_valid = 1, s_data = entry[idx], s_last = (rem == 1).
  - RUN, on a handshake (s_valid & s_ready): idx = (idx == PERIOD-1) ? 0 : idx+1, and rem decrements. A handshake with s_last set returns the FSM to IDLE.
  - st_start while in RUN is ignored.
- **Wrap-around:** the stream wraps through the pattern indefinitely. A stream of 2^AW-1 words is legal.
- **Load port:**
  - wr_en writes entry[wr_idx] = wr_data.
  - The write is ignored when wr_idx ≥ PERIOD.
  - The write is ignored while st_busy = 1, so s_data stays stable under backpressure.
- **Read/write collision:** a read and a write to the same index in the same cycle return the old data.
- **Reset:**
  - Outputs: rd_data = 0, rd_valid = 0, s_valid = 0, s_last = 0, st_busy = 0.
  - FSM returns to IDLE.
  - All entries are restored to the default pattern.
  - A reset asserted mid-stream abandons the stream; there is no partial s_last.

## Timing
- Random port: latency 1; one read per cycle, with no bubbles.
- Stream: st_start in cycle N gives first s_valid in N+1; throughput is 1 word/cycle while s_ready = 1.
- s_data and s_last are stable while s_valid & !s_ready; s_valid never drops before the handshake.
- After the s_last handshake in cycle M:
  - st_busy = 0 in M+1.
  - A new st_start is accepted in M+1, giving first data in M+2.
- A write in cycle N is visible to a read issued in N+1.
- The random port and the stream are independent; both may be active in the same cycle.

## Configuration
- DMEM_LOAD_EN defined:
  - wr_en, wr_idx and wr_data exist.
  - Entries are registers, reset to the default pattern.
- DMEM_LOAD_EN undefined:
  - Load ports are absent.
  - Entries are constants, synthesised as a ROM/mux.
  - Reset affects only the FSM and output registers.

## Test plan
- Default params, after reset, rd_addr = 0, 1, 18, 21, 511 (rd_en each cycle) -> rd_data = 7FFF, 0C88, 8000, 0C88, F378, each one cycle later with rd_valid = 1.
- st_base = 18, st_len = 4, s_ready held 1:
  - s_data = 8000, 0000, 7FFF, 0C88 on consecutive cycles.
  - s_last only on 0C88.
  - st_busy = 0 the next cycle.
- st_base = 5, st_len = 3, s_ready toggling 1,0,0,1,0,1:
  - Exactly 1446, F99E, 0C88 are delivered.
  - s_data is unchanged across stalls.
  - A st_start issued mid-stream is ignored.
- DMEM_LOAD_EN:
  - Write idx 4 = 1234, then rd_addr 24 -> 1234.
  - A write issued during a stream is dropped.
  - rst pulse, then rd_addr 4 -> 0000.
- rst asserted on the 2nd beat of a 10-word stream -> s_valid = 0 and st_busy = 0 next cycle; a new stream at base 0 starts with 7FFF.
- DW = 24, PERIOD = 40: rd_addr 0 -> 7FFF00, rd_addr 26 -> F99E00, rd_addr 45 -> 144600.

Source files
------------

// File: rtl/dmem_pattern_seq.sv
// Repeating PERIOD-entry Q15 pattern over a 2^AW address space: registered random read port
// plus a ready/valid replay sequencer. Define DMEM_LOAD_EN to make the pattern runtime-writable.
module dmem_pattern_seq #(
   parameter int DW     = 16,
   parameter int AW     = 9,
   parameter int PERIOD = 20,
   parameter int IW     = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
   input  logic          clk,
   input  logic          rst,
`ifdef DMEM_LOAD_EN
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [DW-1:0] wr_data,
`endif
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   input  logic          st_start,
   input  logic [AW-1:0] st_base,
   input  logic [AW-1:0] st_len,
   output logic          s_valid,
   input  logic          s_ready,
   output logic [DW-1:0] s_data,
   output logic          s_last,
   output logic          st_busy
);

   typedef enum logic {IDLE, RUN} state_e;

   // Default table value for entry k, left-aligned (or truncated from the MSB) to DW bits.
   function automatic logic [DW-1:0] dflt(input logic [31:0] k);
      logic [15:0]    v;
      logic [DW+15:0] wide;
      case (k % 32'd20)
         32'd0:   v = 16'h7FFF;  32'd1:  v = 16'h0C88;  32'd2:  v = 16'h1897;
         32'd3:   v = 16'h1446;  32'd4:  v = 16'h0000;  32'd5:  v = 16'h1446;
         32'd6:   v = 16'hF99E;  32'd7:  v = 16'h0C88;  32'd8:  v = 16'hFCCA;
         32'd9:   v = 16'h0000;  32'd10: v = 16'h0336;  32'd11: v = 16'hF378;
         32'd12:  v = 16'h0662;  32'd13: v = 16'hEBBA;  32'd14: v = 16'h0000;
         32'd15:  v = 16'hEBBA;  32'd16: v = 16'hE769;  32'd17: v = 16'hF378;
         32'd18:  v = 16'h8000;  default: v = 16'h0000;
      endcase
      wide = {v, {DW{1'b0}}};
      return wide[DW+15 -: DW];
   endfunction

   // One extra bit so PERIOD == 2^AW does not truncate to a zero divisor.
   function automatic logic [IW-1:0] to_idx(input logic [AW-1:0] a);
      logic [AW:0] m;
      m = {1'b0, a} % (AW+1)'(PERIOD);
      return m[IW-1:0];
   endfunction

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [AW-1:0] rem_q, rem_d;
   logic          s_last_q, s_last_d;
   logic [DW-1:0] s_data_q, s_data_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic [IW-1:0] rd_idx;
   logic [DW-1:0] rd_ent, st_ent;

   assign rd_idx = to_idx(rd_addr);

`ifdef DMEM_LOAD_EN
   logic [DW-1:0] mem_q [PERIOD];
   logic [DW-1:0] mem_d [PERIOD];

   // Writes are frozen during a stream so a stalled s_data can never change underneath.
   always_comb begin
      mem_d = mem_q;
      if (wr_en && state_q == IDLE && 32'(wr_idx) < PERIOD)
         mem_d[wr_idx] = wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PERIOD; i++) mem_q[i] <= dflt(32'(i));
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_ent = mem_q[rd_idx];
   assign st_ent = mem_d[idx_d];
`else
   assign rd_ent = dflt(32'(rd_idx));
   assign st_ent = dflt(32'(idx_d));
`endif

   always_comb begin
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? rd_ent : rd_data_q;
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      rem_d    = rem_q;
      s_last_d = s_last_q;
      case (state_q)
         IDLE: if (st_start && st_len != '0) begin
            state_d  = RUN;
            idx_d    = to_idx(st_base);
            rem_d    = st_len;
            s_last_d = (st_len == AW'(1));
         end
         RUN: if (s_ready) begin
            if (s_last_q) begin
               state_d  = IDLE;
               s_last_d = 1'b0;
            end else begin
               idx_d    = (idx_q == IW'(PERIOD-1)) ? '0 : idx_q + 1'b1;
               rem_d    = rem_q - 1'b1;
               s_last_d = (rem_q == AW'(2));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_data_d = (state_d == RUN) ? st_ent : s_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         rem_q      <= '0;
         s_last_q   <= 1'b0;
         s_data_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         s_last_q   <= s_last_d;
         s_data_q   <= s_data_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign s_valid  = (state_q == RUN);
   assign st_busy  = (state_q == RUN);
   assign s_last   = s_last_q;
   assign s_data   = s_data_q;

endmodule

// File: tb/tb_dmem_pattern_seq.sv
// Scoreboard bench for dmem_pattern_seq: a queue-based reference model predicts read and
// stream words; a negedge monitor pops and compares. A second instance checks DW=24/PERIOD=40.
module tb_dmem_pattern_seq;

   localparam int DW = 16, AW = 9, P = 20, IW = 5;
   localparam int DW2 = 24, P2 = 40, IW2 = 6;
   localparam logic [15:0] TAB [20] = '{
      16'h7FFF, 16'h0C88, 16'h1897, 16'h1446, 16'h0000, 16'h1446, 16'hF99E, 16'h0C88,
      16'hFCCA, 16'h0000, 16'h0336, 16'hF378, 16'h0662, 16'hEBBA, 16'h0000, 16'hEBBA,
      16'hE769, 16'hF378, 16'h8000, 16'h0000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          rd_en = 0, st_start = 0, s_ready = 0;
   logic [AW-1:0] rd_addr = '0, st_base = '0, st_len = '0;
   logic [DW-1:0] rd_data, s_data;
   logic          rd_valid, s_valid, s_last, st_busy;
   logic          wr_en = 0;
   logic [IW-1:0] wr_idx = '0;
   logic [DW-1:0] wr_data = '0;

   logic           r2_en = 0;
   logic [AW-1:0]  r2_addr = '0;
   logic [DW2-1:0] r2_data, s2_data;
   logic           r2_valid, s2_valid, s2_last, s2_busy;
   logic           w2_en = 0;
   logic [IW2-1:0] w2_idx = '0;
   logic [DW2-1:0] w2_data = '0;

   dmem_pattern_seq #(.DW(DW), .AW(AW), .PERIOD(P)) dut (
      .clk(clk), .rst(rst),
`ifdef DMEM_LOAD_EN
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
`endif
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .st_start(st_start), .st_base(st_base), .st_len(st_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .st_busy(st_busy));

   dmem_pattern_seq #(.DW(DW2), .AW(AW), .PERIOD(P2)) dut2 (
      .clk(clk), .rst(rst),
`ifdef DMEM_LOAD_EN
      .wr_en(w2_en), .wr_idx(w2_idx), .wr_data(w2_data),
`endif
      .rd_en(r2_en), .rd_addr(r2_addr), .rd_data(r2_data), .rd_valid(r2_valid),
      .st_start(1'b0), .st_base('0), .st_len('0),
      .s_valid(s2_valid), .s_ready(1'b1), .s_data(s2_data), .s_last(s2_last),
      .st_busy(s2_busy));

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] scale(input logic [15:0] v, input int dw);
      if (dw >= 16) return 64'(v) << (dw - 16);
      return 64'(v) >> (16 - dw);
   endfunction

   // Reference model: pattern contents, expected read/stream words, stream activity.
   logic [DW-1:0] mmem [P];
   logic [DW-1:0] rq [$];
   logic [DW-1:0] sq [$];
   logic [DW-1:0] rd_last = '0;
   bit            m_act = 0;
   int            m_rem = 0;

   task automatic mreset();
      for (int i = 0; i < P; i++) mmem[i] = DW'(scale(TAB[i % 20], DW));
   endtask

   always @(posedge clk) begin
      bit busy;
      busy = m_act;
      if (rst) begin
         m_act = 0; m_rem = 0;
         sq.delete(); rq.delete();
         mreset();
         rd_last = '0;
      end else begin
         if (rd_en) rq.push_back(mmem[int'(rd_addr) % P]);
`ifdef DMEM_LOAD_EN
         if (wr_en && !busy && int'(wr_idx) < P) mmem[wr_idx] = wr_data;
`endif
         if (busy) begin
            if (s_ready) begin
               m_rem--;
               if (m_rem == 0) m_act = 0;
            end
         end else if (st_start && st_len != 0) begin
            m_act = 1;
            m_rem = int'(st_len);
            for (int i = 0; i < int'(st_len); i++)
               sq.push_back(mmem[(int'(st_base) + i) % P]);
         end
      end
   end

   always @(negedge clk) begin
      logic [DW-1:0] e;
      chk("st_busy", st_busy, m_act);
      chk("s_valid", s_valid, m_act);
      if (rd_valid) begin
         if (rq.size() == 0) chk("rd_valid_spurious", 1, 0);
         else begin
            e = rq.pop_front();
            chk("rd_data", rd_data, e);
            rd_last = e;
         end
      end else chk("rd_data_hold", rd_data, rd_last);
      if (s_valid && m_act) begin
         if (sq.size() == 0) chk("s_valid_spurious", 1, 0);
         else begin
            chk("s_data", s_data, sq[0]);
            chk("s_last", s_last, sq.size() == 1);
            if (s_ready) void'(sq.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int base, input int len);
      st_start = 1; st_base = AW'(base); st_len = AW'(len);
      tick();
      st_start = 0;
   endtask

   initial begin
      int  a1 [5] = '{0, 1, 18, 21, 511};
      bit  pat [6] = '{1, 0, 0, 1, 0, 1};
      int  a2 [3] = '{0, 26, 45};

      repeat (3) tick();
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_s_valid", s_valid, 0);
      chk("rst_s_last", s_last, 0);
      chk("rst_st_busy", st_busy, 0);
      rst = 0;
      tick();

      // Random port: back-to-back reads including wrap addresses.
      foreach (a1[i]) begin
         rd_en = 1; rd_addr = AW'(a1[i]);
         tick();
      end
      rd_en = 0;
      repeat (2) tick();

      // Stream wrapping across the period end, no backpressure.
      s_ready = 1;
      start(18, 4);
      repeat (6) tick();

      // Backpressured stream with an ignored mid-stream start.
      start(5, 3);
      foreach (pat[i]) begin
         s_ready = pat[i];
         if (i == 1) begin st_start = 1; st_base = '0; st_len = AW'(7); end
         tick();
         st_start = 0;
      end
      s_ready = 1;
      repeat (3) tick();
      chk("bp_drained", sq.size(), 0);

      // Zero-length start is ignored.
      start(3, 0);
      repeat (2) tick();

`ifdef DMEM_LOAD_EN
      wr_en = 1; wr_idx = IW'(4); wr_data = 16'h1234;
      tick();
      wr_en = 0; rd_en = 1; rd_addr = AW'(24);
      tick();
      rd_en = 0;
      start(0, 5);
      wr_en = 1; wr_idx = IW'(9); wr_data = 16'hABCD;
      tick();
      wr_en = 0;
      repeat (6) tick();
      rd_en = 1; rd_addr = AW'(9);
      tick();
      rd_en = 0;
      rst = 1; tick(); rst = 0;
      rd_en = 1; rd_addr = AW'(4);
      tick();
      rd_en = 0;
      tick();
`endif

      // Reset during the second beat of a 10-word stream.
      s_ready = 1;
      start(7, 10);
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("midrst_s_valid", s_valid, 0);
      chk("midrst_st_busy", st_busy, 0);
      start(0, 2);
      repeat (3) tick();

      // Longest legal stream, wrapping the pattern many times.
      start(3, 511);
      repeat (515) tick();
      chk("long_drained", sq.size(), 0);

      // Randomised traffic on both ports.
      for (int c = 0; c < 3000; c++) begin
         rd_en    = ($urandom % 2) == 0;
         rd_addr  = AW'($urandom);
         s_ready  = ($urandom % 4) != 0;
         st_start = ($urandom % 8) == 0;
         st_base  = AW'($urandom);
         st_len   = (($urandom % 6) == 0) ? '0 : AW'($urandom_range(1, 12));
         wr_en    = ($urandom % 4) == 0;
         wr_idx   = IW'($urandom % 32);
         wr_data  = DW'($urandom);
         rst      = ($urandom % 500) == 0;
         tick();
      end
      rst = 0; rd_en = 0; st_start = 0; wr_en = 0; s_ready = 1;
      repeat (20) tick();
      chk("rand_s_drained", sq.size(), 0);
      chk("rand_r_drained", rq.size(), 0);

      // Wide, longer-period instance.
      foreach (a2[i]) begin
         r2_en = 1; r2_addr = AW'(a2[i]);
         tick();
         chk("w24_rd_valid", r2_valid, 1);
         chk("w24_rd_data", r2_data, scale(TAB[(a2[i] % P2) % 20], DW2));
      end
      for (int i = 0; i < 8; i++) begin
         int a;
         a = $urandom_range(0, 511);
         r2_en = 1; r2_addr = AW'(a);
         tick();
         chk("w24_rand", r2_data, scale(TAB[(a % P2) % 20], DW2));
      end
      r2_en = 0;
      tick();
      chk("w24_rd_idle", r2_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
